// File: rtl/sdram_arb_pkg.sv
// Shared constants, command type and helpers for the SDRAM command arbiter.
package sdram_arb_pkg;

   localparam int SDRAMAddrWidth = 23;
   localparam int SDRAMDataWidth = 16;

   typedef struct packed {
      logic                      write;
      logic [SDRAMAddrWidth-1:0] addr;
      logic [SDRAMDataWidth-1:0] writeData;
   } sdram_cmd_t;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // A single requester still needs one bit to name it.
   function automatic int port_id_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Small FIFO of requester ids, one entry per read issued to the controller.
module sdram_tag_fifo #(
   parameter  int Width = 1,
   parameter  int Depth = 4,
   localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
   localparam int CntW  = $clog2(Depth) + 1
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             push_i,
   input  logic [Width-1:0] push_data_i,
   input  logic             pop_i,
   output logic [Width-1:0] head_o,
   output logic [CntW-1:0]  count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_q, wr_d;
   logic [PtrW-1:0]  rd_q, rd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   // Depth is a power of two, so the pointers wrap on their own.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push_i) wr_d = wr_q + PtrW'(1);
      if (pop_i)  rd_d = rd_q + PtrW'(1);
      case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Shares the SDRAM controller command port among several requesters and routes read data back.
// Define SDRAM_ARB_ROUNDROBIN_EN for round-robin grants; otherwise lowest port wins.
module sdram_cmd_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int Ports    = 2,
   parameter int TagDepth = 4
) (
   input  logic                               clk,
   input  logic                               rst_,
   input  logic [Ports-1:0]                   reqTrigger,
   output logic [Ports-1:0]                   reqReady,
   input  logic [Ports-1:0]                   reqWrite,
   input  logic [Ports*SDRAMAddrWidth-1:0]    reqAddr,
   input  logic [Ports*SDRAMDataWidth-1:0]    reqWriteData,
   output logic [SDRAMDataWidth-1:0]          reqReadData,
   output logic [Ports-1:0]                   reqReadDataValid,
   input  logic                               cmdReady,
   output logic                               cmdTrigger,
   output logic                               cmdWrite,
   output logic [SDRAMAddrWidth-1:0]          cmdAddr,
   output logic [SDRAMDataWidth-1:0]          cmdWriteData,
   input  logic [SDRAMDataWidth-1:0]          cmdReadData,
   input  logic                               cmdReadDataValid,
   output logic                               errTagUnderflow
);

   localparam int PortW = port_id_width(Ports);
   localparam int CntW  = $clog2(TagDepth) + 1;

   slot_state_e      state_q;
   sdram_cmd_t       cmd_q, cmd_d;
   logic [PortW-1:0] slot_port_q;
   logic             err_q, err_d;

   sdram_cmd_t       req_cmd [Ports];
   logic [Ports-1:0] eligible;
   logic             read_ok;
   int               outstanding;
   logic             slot_free, accept, grant;
   logic             win_found;
   logic [PortW-1:0] winner;

   logic             tag_push, tag_pop;
   logic [PortW-1:0] tag_head;
   logic [CntW-1:0]  tag_count;
   logic             tag_empty, tag_full;

   always_comb begin
      for (int i = 0; i < Ports; i++) begin
         req_cmd[i].write     = reqWrite[i];
         req_cmd[i].addr      = reqAddr[SDRAMAddrWidth*i +: SDRAMAddrWidth];
         req_cmd[i].writeData = reqWriteData[SDRAMDataWidth*i +: SDRAMDataWidth];
      end
   end

   // A read still sitting in the slot already holds a tag in the reckoning.
   always_comb begin
      outstanding = int'(tag_count);
      if (state_q == SLOT_FULL && !cmd_q.write) outstanding = outstanding + 1;
   end

   assign read_ok   = (outstanding < TagDepth);
   assign eligible  = reqTrigger & (reqWrite | {Ports{read_ok}});
   assign accept    = (state_q == SLOT_FULL) && cmdReady;
   assign slot_free = (state_q == SLOT_EMPTY) || cmdReady;
   assign grant     = win_found && slot_free;

`ifdef SDRAM_ARB_ROUNDROBIN_EN
   logic [PortW-1:0] last_q, last_d;
   int               rr_start, rr_idx;

   always_comb begin
      win_found = 1'b0;
      winner    = '0;
      rr_idx    = 0;
      rr_start  = (int'(last_q) + 1) % Ports;
      for (int k = 0; k < Ports; k++) begin
         rr_idx = (rr_start + k) % Ports;
         if (!win_found && eligible[rr_idx]) begin
            win_found = 1'b1;
            winner    = PortW'(rr_idx);
         end
      end
   end

   assign last_d = grant ? winner : last_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) last_q <= '0;
      else       last_q <= last_d;
   end
`else
   always_comb begin
      win_found = 1'b0;
      winner    = '0;
      for (int i = 0; i < Ports; i++) begin
         if (!win_found && eligible[i]) begin
            win_found = 1'b1;
            winner    = PortW'(i);
         end
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < Ports; i++) reqReady[i] = grant && (winner == PortW'(i));
   end

   assign cmd_d = req_cmd[winner];

   // Accept and refill share an edge, so a grant overrides the FULL->EMPTY move.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q     <= SLOT_EMPTY;
         cmd_q       <= '0;
         slot_port_q <= '0;
      end else begin
         case (state_q)
            SLOT_EMPTY: begin
               if (grant) begin
                  state_q     <= SLOT_FULL;
                  cmd_q       <= cmd_d;
                  slot_port_q <= winner;
               end
            end
            SLOT_FULL: begin
               if (grant) begin
                  cmd_q       <= cmd_d;
                  slot_port_q <= winner;
               end else if (cmdReady) begin
                  state_q     <= SLOT_EMPTY;
               end
            end
            default: state_q <= SLOT_EMPTY;
         endcase
      end
   end

   assign tag_push = accept && !cmd_q.write && (!tag_full || tag_pop);
   assign tag_pop  = cmdReadDataValid && !tag_empty;

   sdram_tag_fifo #(
      .Width (PortW),
      .Depth (TagDepth)
   ) u_tag_fifo (
      .clk         (clk),
      .rst_        (rst_),
      .push_i      (tag_push),
      .push_data_i (slot_port_q),
      .pop_i       (tag_pop),
      .head_o      (tag_head),
      .count_o     (tag_count),
      .empty_o     (tag_empty),
      .full_o      (tag_full)
   );

   always_comb begin
      for (int i = 0; i < Ports; i++) reqReadDataValid[i] = tag_pop && (tag_head == PortW'(i));
   end

   assign err_d = err_q || (cmdReadDataValid && tag_empty);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign reqReadData     = cmdReadData;
   assign cmdTrigger      = (state_q == SLOT_FULL);
   assign cmdWrite        = cmd_q.write;
   assign cmdAddr         = cmd_q.addr;
   assign cmdWriteData    = cmd_q.writeData;
   assign errTagUnderflow = err_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Scoreboard bench for sdram_cmd_arbiter: directed stimulus queues expectations, a negedge monitor checks them.
module tb_sdram_cmd_arbiter;

   logic        clk;
   logic        rst_;
   logic [1:0]  reqTrigger, reqReady, reqWrite, reqReadDataValid;
   logic [45:0] reqAddr;
   logic [31:0] reqWriteData;
   logic [15:0] reqReadData;
   logic        cmdReady, cmdTrigger, cmdWrite;
   logic [22:0] cmdAddr;
   logic [15:0] cmdWriteData;
   logic [15:0] cmdReadData;
   logic        cmdReadDataValid;
   logic        errTagUnderflow;

   int          checks = 0;
   int          errors = 0;

   int          exp_grant [$];
   logic [39:0] exp_cmd   [$];
   logic [17:0] exp_rd    [$];

   sdram_cmd_arbiter #(.Ports(2), .TagDepth(4)) dut (
      .clk              (clk),
      .rst_             (rst_),
      .reqTrigger       (reqTrigger),
      .reqReady         (reqReady),
      .reqWrite         (reqWrite),
      .reqAddr          (reqAddr),
      .reqWriteData     (reqWriteData),
      .reqReadData      (reqReadData),
      .reqReadDataValid (reqReadDataValid),
      .cmdReady         (cmdReady),
      .cmdTrigger       (cmdTrigger),
      .cmdWrite         (cmdWrite),
      .cmdAddr          (cmdAddr),
      .cmdWriteData     (cmdWriteData),
      .cmdReadData      (cmdReadData),
      .cmdReadDataValid (cmdReadDataValid),
      .errTagUnderflow  (errTagUnderflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester: present a command, wait for its reqReady, then drop the trigger.
   task automatic issue(input int port, input logic wr, input logic [22:0] addr, input logic [15:0] wd);
      int n;
      exp_grant.push_back(port);
      exp_cmd.push_back({wr, addr, wd});
      reqWrite[port]             = wr;
      reqAddr[23*port +: 23]     = addr;
      reqWriteData[16*port +: 16] = wd;
      reqTrigger[port]           = 1'b1;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (reqReady[port]) break;
      end
      if (n == 20) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout port=%0d actual=no_reqReady expected=reqReady", port);
      end
      tick();
      reqTrigger[port] = 1'b0;
   endtask

   // Monitor: every grant, accepted command and read return must match the head of its queue.
   always @(negedge clk) begin
      int          p;
      logic [1:0]  eg;
      logic [39:0] ec;
      logic [17:0] er;
      if (rst_) begin
         if (reqReady !== 2'b00) begin
            if (exp_grant.size() == 0) check("unexpected_grant", 64'(reqReady), 64'd0);
            else begin
               p  = exp_grant.pop_front();
               eg = 2'b01 << p;
               check("grant", 64'(reqReady), 64'(eg));
            end
         end
         if (cmdTrigger === 1'b1 && cmdReady === 1'b1) begin
            if (exp_cmd.size() == 0) check("unexpected_cmd", 64'({cmdWrite, cmdAddr, cmdWriteData}), 64'd0);
            else begin
               ec = exp_cmd.pop_front();
               check("cmd_fields", 64'({cmdWrite, cmdAddr, cmdWriteData}), 64'(ec));
            end
         end
         if (reqReadDataValid !== 2'b00) begin
            if (exp_rd.size() == 0) check("unexpected_rdvalid", 64'({reqReadDataValid, reqReadData}), 64'd0);
            else begin
               er = exp_rd.pop_front();
               check("read_return", 64'({reqReadDataValid, reqReadData}), 64'(er));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ord [4];
      rst_             = 1'b0;
      reqTrigger       = '0;
      reqWrite         = '0;
      reqAddr          = '0;
      reqWriteData     = '0;
      cmdReady         = 1'b0;
      cmdReadData      = '0;
      cmdReadDataValid = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_cmdTrigger", 64'(cmdTrigger), 64'd0);
      check("rst_cmdWrite", 64'(cmdWrite), 64'd0);
      check("rst_cmdAddr", 64'(cmdAddr), 64'd0);
      check("rst_cmdWriteData", 64'(cmdWriteData), 64'd0);
      check("rst_reqReady", 64'(reqReady), 64'd0);
      check("rst_reqReadDataValid", 64'(reqReadDataValid), 64'd0);
      check("rst_errTagUnderflow", 64'(errTagUnderflow), 64'd0);
      tick();
      rst_     = 1'b1;
      cmdReady = 1'b1;
      tick();

      // Single read from port 1, data returned three cycles after acceptance.
      issue(1, 1'b0, 23'h000010, 16'h0000);
      repeat (3) tick();
      exp_rd.push_back({2'b10, 16'hBEEF});
      cmdReadData      = 16'hBEEF;
      cmdReadDataValid = 1'b1;
      tick();
      cmdReadDataValid = 1'b0;
      tick();

      // Contention: both ports hold write requests for four grants.
`ifdef SDRAM_ARB_ROUNDROBIN_EN
      ord = '{0, 1, 0, 1};
`else
      ord = '{0, 0, 0, 0};
`endif
      reqWrite     = 2'b11;
      reqAddr      = {23'h000222, 23'h000111};
      reqWriteData = {16'hB1B1, 16'hA0A0};
      for (int k = 0; k < 4; k++) begin
         exp_grant.push_back(ord[k]);
         exp_cmd.push_back(ord[k] == 0 ? {1'b1, 23'h000111, 16'hA0A0} : {1'b1, 23'h000222, 16'hB1B1});
      end
      reqTrigger = 2'b11;
      repeat (4) tick();
      reqTrigger = 2'b00;
      repeat (2) tick();

      // Controller stall with a write in the slot and port 1 waiting.
      cmdReady = 1'b0;
      exp_grant.push_back(0);
      exp_cmd.push_back({1'b1, 23'h05A5A5, 16'hC0DE});
      exp_grant.push_back(1);
      exp_cmd.push_back({1'b1, 23'h7FFFFF, 16'hFFFF});
      reqAddr[22:0]      = 23'h05A5A5;
      reqWriteData[15:0] = 16'hC0DE;
      reqTrigger         = 2'b01;
      @(negedge clk);
      tick();
      reqAddr[45:23]      = 23'h7FFFFF;
      reqWriteData[31:16] = 16'hFFFF;
      reqTrigger          = 2'b10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_cmdTrigger", 64'(cmdTrigger), 64'd1);
         check("stall_fields", 64'({cmdWrite, cmdAddr, cmdWriteData}), 64'({1'b1, 23'h05A5A5, 16'hC0DE}));
         check("stall_no_reqReady", 64'(reqReady), 64'd0);
         tick();
      end
      cmdReady = 1'b1;
      @(negedge clk);
      check("release_regrant", 64'(reqReady), 64'd2);
      tick();
      reqTrigger = 2'b00;
      tick();

      // Tag limit: four reads fill the tags, the fifth waits for a return.
      reqWrite     = 2'b00;
      reqWriteData = '0;
      for (int k = 0; k < 4; k++) issue(0, 1'b0, 23'(23'h000100 + k), 16'h0000);
      reqAddr[22:0] = 23'h000104;
      reqTrigger[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("taglimit_hold", 64'(reqReady), 64'd0);
         tick();
      end
      exp_rd.push_back({2'b01, 16'h0A0A});
      cmdReadData      = 16'h0A0A;
      cmdReadDataValid = 1'b1;
      @(negedge clk);
      check("taglimit_hold_on_return", 64'(reqReady), 64'd0);
      exp_grant.push_back(0);
      exp_cmd.push_back({1'b0, 23'h000104, 16'h0000});
      tick();
      cmdReadDataValid = 1'b0;
      @(negedge clk);
      check("taglimit_fifth_granted", 64'(reqReady), 64'd1);
      tick();
      reqTrigger[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp_rd.push_back({2'b01, 16'(16'h0B00 + k)});
         cmdReadData      = 16'(16'h0B00 + k);
         cmdReadDataValid = 1'b1;
         tick();
      end
      cmdReadDataValid = 1'b0;
      tick();

      // Interleaved reads; the first return coincides with the third read's acceptance.
      issue(0, 1'b0, 23'h000200, 16'h0000);
      issue(1, 1'b0, 23'h000201, 16'h0000);
      issue(0, 1'b0, 23'h000202, 16'h0000);
      exp_rd.push_back({2'b01, 16'h1111});
      cmdReadData      = 16'h1111;
      cmdReadDataValid = 1'b1;
      @(negedge clk);
      check("occupancy_before_pushpop", 64'(dut.u_tag_fifo.count_o), 64'd2);
      tick();
      exp_rd.push_back({2'b10, 16'h2222});
      cmdReadData = 16'h2222;
      @(negedge clk);
      check("occupancy_after_pushpop", 64'(dut.u_tag_fifo.count_o), 64'd2);
      tick();
      exp_rd.push_back({2'b01, 16'h3333});
      cmdReadData = 16'h3333;
      tick();
      cmdReadDataValid = 1'b0;
      @(negedge clk);
      check("occupancy_drained", 64'(dut.u_tag_fifo.count_o), 64'd0);
      tick();

      // Spurious return with no outstanding read.
      cmdReadData      = 16'hDEAD;
      cmdReadDataValid = 1'b1;
      @(negedge clk);
      check("spurious_no_valid", 64'(reqReadDataValid), 64'd0);
      tick();
      cmdReadDataValid = 1'b0;
      @(negedge clk);
      check("underflow_set", 64'(errTagUnderflow), 64'd1);
      repeat (3) tick();
      @(negedge clk);
      check("underflow_sticky", 64'(errTagUnderflow), 64'd1);
      tick();

      // Leave one read outstanding and a write stalled, then reset mid-cycle.
      issue(0, 1'b0, 23'h0ABCDE, 16'h0000);
      tick();
      cmdReady = 1'b0;
      exp_grant.push_back(0);
      reqWrite[0]   = 1'b1;
      reqAddr[22:0] = 23'h000333;
      reqTrigger[0] = 1'b1;
      @(negedge clk);
      tick();
      reqTrigger[0] = 1'b0;
      @(negedge clk);
      check("stall_before_reset", 64'(cmdTrigger), 64'd1);
      @(posedge clk);
      #3;
      rst_ = 1'b0;
      #1;
      check("async_rst_cmdTrigger", 64'(cmdTrigger), 64'd0);
      check("async_rst_cmdAddr", 64'(cmdAddr), 64'd0);
      check("async_rst_errTagUnderflow", 64'(errTagUnderflow), 64'd0);
      tick();
      rst_             = 1'b1;
      cmdReady         = 1'b1;
      cmdReadDataValid = 1'b1;
      @(negedge clk);
      check("post_reset_no_valid", 64'(reqReadDataValid), 64'd0);
      tick();
      cmdReadDataValid = 1'b0;
      @(negedge clk);
      check("post_reset_fifo_empty", 64'(errTagUnderflow), 64'd1);
      tick();

      check("grants_left", 64'(exp_grant.size()), 64'd0);
      check("cmds_left", 64'(exp_cmd.size()), 64'd0);
      check("reads_left", 64'(exp_rd.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_cmd_arbiter.md
# sdram_cmd_arbiter

Shares the single command port of the SDRAM controller between several requesters, such as the UART debug path and the future camera/DMA paths. Each requester sees the same trigger/ready/read-data handshake that the controller itself presents. The arbiter latches one winning command at a time, drives it to the controller, and tags every issued read. Returned read data is then routed back to the requester that issued it.

## Interface
- `Ports`, 2: number of requesters, legal range 2–4.
- `TagDepth`, 4: maximum outstanding reads; power of two, 2–8.
- `clk` in 1: system clock, shared with the SDRAM controller.
- `rst_` in 1: asynchronous, active-low reset.
- `reqTrigger` in `Ports`: per-port command request, held until accepted.
- `reqReady` out `Ports`: one-hot pulse; the command on that port is accepted this cycle.
- `reqWrite` in `Ports`: per-port 1 = write, 0 = read.
- `reqAddr` in `Ports*23`: packed per-port word address; port i occupies `[23*i+:23]`.
- `reqWriteData` in `Ports*16`: packed per-port write data.
- `reqReadData` out 16: copy of `cmdReadData`, common to all ports.
- `reqReadDataValid` out `Ports`: one-hot; read data belongs to this port.
- `cmdReady` in 1: controller accepts `cmdTrigger` this cycle.
- `cmdTrigger`, `cmdWrite`, `cmdAddr[22:0]`, `cmdWriteData[15:0]` out: command to the controller.
- `cmdReadData` in 16, `cmdReadDataValid` in 1: read return from the controller.
- `errTagUnderflow` out 1: sticky error; `cmdReadDataValid` arrived with no outstanding read.

## Operation
- **Command slot.** One registered slot: `cmdTrigger`, `cmdWrite`, `cmdAddr`, `cmdWriteData`, plus the owner port id `slotPort`.
- **Slot states.**
  - EMPTY (`cmdTrigger`=0).
  - FULL (`cmdTrigger`=1).
  - FULL→EMPTY on `cmdTrigger && cmdReady`.
  - Refill in the same cycle is allowed, so back-to-back commands are possible.
- **Grant.** A grant is evaluated only when the slot is EMPTY or is being accepted this cycle. The winner is chosen among ports with `reqTrigger[i]`=1 that are eligible.
- **Eligibility.**
  - Writes are always eligible.
  - A read is eligible only if `outstanding < TagDepth`.
  - `outstanding` = tag FIFO occupancy + 1 if the slot holds an unaccepted read.
- **On grant.** `reqReady[winner]`=1 for that cycle. The slot loads the winner's fields on the same edge, and `slotPort` ← winner.
- **Read tagging.** On `cmdTrigger && cmdReady && !cmdWrite`, `slotPort` is pushed into the tag FIFO.
- **Read return.** On `cmdReadDataValid` with the FIFO non-empty:
  - pop the FIFO;
  - set `reqReadDataValid[head]`=1 combinationally from the FIFO head;
  - `reqReadData` = `cmdReadData`.
- **Simultaneous push and pop.** Both happen in the same cycle; occupancy is unchanged.
- **Underflow.** `cmdReadDataValid` with the FIFO empty asserts no `reqReadDataValid` and sets `errTagUnderflow`, which stays set until reset.
- **Reset mid-operation.** All state clears immediately:
  - the slot is dropped and `cmdTrigger`=0;
  - the FIFO empties;
  - the round-robin pointer resets to 0.

  The controller is reset by the same `rst_`, so no command is left half-issued.

## Timing
- **Reset values.** `cmdTrigger`=0, `cmdWrite`=0, `cmdAddr`=0, `cmdWriteData`=0, `reqReady`=0, `reqReadDataValid`=0, `errTagUnderflow`=0.
- **Issue latency.** `reqReady` in cycle N; `cmdTrigger` is high from cycle N+1.
- **Slot hold.** `cmdTrigger` and the command fields stay stable until `cmdReady`.
- **Sustained rate.** With `cmdReady` held high, one command per cycle.
- **Read-return latency.** Zero cycles: `reqReadDataValid` and `reqReadData` are valid in the same cycle as `cmdReadDataValid`.
- **Combinational paths.** `reqReady` is combinational from `reqTrigger`, `cmdReady` and state. The requester must keep its command fields valid while `reqTrigger` is high.

## Configuration
- **`SDRAM_ARB_ROUNDROBIN_EN` defined.**
  - Round-robin arbitration: the search starts at `lastGrant+1` modulo `Ports`.
  - `lastGrant` updates on every grant.
- **Undefined.**
  - Fixed priority: the lowest-numbered eligible port wins.
  - The pointer logic is absent.

## Structure
- **Package `sdram_arb_pkg`.**
  - Constants `SDRAMAddrWidth`=23 and `SDRAMDataWidth`=16.
  - Typedef `sdram_cmd_t` = {write, addr, writeData}.
  - A port-id width function (`$clog2(Ports)`, minimum 1).
- **Sub-module `sdram_tag_fifo`.**
  - Parameterised by width and depth.
  - Push/pop/head/count/empty/full.
  - Asynchronous active-low reset.

## Test plan
- **Single read.** Port 1 reads 23'h000010 and the controller returns 16'hBEEF after 3 cycles → `reqReadDataValid`=2'b10 with `reqReadData`=16'hBEEF. Port 0 sees no valid.
- **Contention.** Ports 0 and 1 both trigger writes continuously for 4 commands with `cmdReady`=1:
  - with `SDRAM_ARB_ROUNDROBIN_EN` → grant order 0,1,0,1;
  - without it → 0,0,0,0 while port 0 holds `reqTrigger`.
- **Controller stall.** Hold `cmdReady`=0 for 10 cycles with a command in the slot → `cmdTrigger`=1 and fields unchanged throughout, and no `reqReady` pulses. Release → accept, then the next grant in the same cycle.
- **Tag limit.** `TagDepth`=4, port 0 issues 5 reads while the controller withholds data → 4 reads accepted and the fifth `reqReady` is withheld. One data return → the fifth read is granted next cycle.
- **Interleaved reads.** Ports 0,1,0 issue reads returning 16'h1111, 16'h2222, 16'h3333 in order → `reqReadDataValid` order 01,10,01 with matching data. Also push and pop in the same cycle → occupancy unchanged.
- **Spurious return and reset.**
  - `cmdReadDataValid` with the FIFO empty → `errTagUnderflow`=1 and sticky.
  - Then `rst_` low mid-stall → `cmdTrigger` and `errTagUnderflow` fall asynchronously.
